// File: rtl/vga_sync_receiver_if.sv
// Incoming VGA stream plus the receiver's recovered-pixel and frame-status outputs.
// The video source holds the master modport; the receiver holds the slave modport.
interface vga_sync_receiver_if;
  logic        hsync;
  logic        vsync;
  logic        blank_b;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        rx_valid;
  logic [9:0]  rx_x;
  logic [9:0]  rx_y;
  logic [23:0] rx_rgb;
  logic [9:0]  line_period;
  logic [9:0]  frame_lines;
  logic [31:0] frame_sum;
  logic        frame_done;
  logic        locked;
  logic        err;

  modport master (
    output hsync, vsync, blank_b, red, green, blue,
    input  rx_valid, rx_x, rx_y, rx_rgb, line_period, frame_lines, frame_sum,
    input  frame_done, locked, err
  );

  modport slave (
    input  hsync, vsync, blank_b, red, green, blue,
    output rx_valid, rx_x, rx_y, rx_rgb, line_period, frame_lines, frame_sum,
    output frame_done, locked, err
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA stream receiver: recovers pixel coordinates, measures line/frame timing,
// sums RGB per frame and declares lock after consecutive conforming frames.
module vga_sync_receiver #(
  parameter int unsigned HMAX        = 800,
  parameter int unsigned VMAX        = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                 vgaclk,
  input logic                 btn_reset_right,
  vga_sync_receiver_if.slave  vid
);

  localparam logic [9:0] HPeriod = 10'(HMAX);
  localparam logic [9:0] VLines  = 10'(VMAX);
  localparam logic [1:0] LockCnt = 2'(LOCK_FRAMES);
  localparam logic [9:0] CntMax  = 10'h3ff;

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e      state_q;
  logic        s1_hsync, s1_vsync, s1_blank, s2_hsync, s2_vsync;
  logic [7:0]  s1_red, s1_green, s1_blue;
  logic [9:0]  hper_q, xcnt_q, ycnt_q, lcnt_q;
  logic        h_seen_q, line_act_q, fbad_q;
  logic [31:0] acc_q;
  logic [1:0]  good_q;
  logic        rx_valid_q, frame_done_q, locked_q, err_q;
  logic [9:0]  rx_x_q, rx_y_q, line_period_q, frame_lines_q;
  logic [23:0] rx_rgb_q;
  logic [31:0] frame_sum_q;
  logic        hs_edge, vs_edge, bad_line;

  assign hs_edge = s2_hsync & ~s1_hsync;
  assign vs_edge = s2_vsync & ~s1_vsync;
  // Wrong period on a seen line, or the period counter about to saturate (sync lost).
  assign bad_line = (hs_edge & h_seen_q & (hper_q != HPeriod)) |
                    (~hs_edge & (hper_q == CntMax - 10'd1));

  always_ff @(posedge vgaclk or posedge btn_reset_right) begin
    if (btn_reset_right) begin
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s1_blank <= 1'b0;
      s1_red   <= '0;
      s1_green <= '0;
      s1_blue  <= '0;
      s2_hsync <= 1'b0;
      s2_vsync <= 1'b0;
    end else begin
      s1_hsync <= vid.hsync;
      s1_vsync <= vid.vsync;
      s1_blank <= vid.blank_b;
      s1_red   <= vid.red;
      s1_green <= vid.green;
      s1_blue  <= vid.blue;
      s2_hsync <= s1_hsync;
      s2_vsync <= s1_vsync;
    end
  end

  always_ff @(posedge vgaclk or posedge btn_reset_right) begin
    if (btn_reset_right) begin
      hper_q        <= '0;
      xcnt_q        <= '0;
      ycnt_q        <= '0;
      lcnt_q        <= '0;
      h_seen_q      <= 1'b0;
      line_act_q    <= 1'b0;
      acc_q         <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
      frame_sum_q   <= '0;
      frame_done_q  <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_rgb_q      <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (hs_edge) begin
        hper_q        <= 10'd1;
        line_period_q <= hper_q;
        h_seen_q      <= 1'b1;
        xcnt_q        <= '0;
        line_act_q    <= 1'b0;
      end else begin
        if (hper_q != CntMax) hper_q <= hper_q + 10'd1;
        if (s1_blank) begin
          xcnt_q     <= xcnt_q + 10'd1;
          line_act_q <= 1'b1;
        end
      end
      if (vs_edge) begin
        ycnt_q        <= '0;
        lcnt_q        <= '0;
        // A line ending in the same cycle still belongs to the closing frame.
        frame_lines_q <= (hs_edge && lcnt_q != CntMax) ? lcnt_q + 10'd1 : lcnt_q;
        frame_sum_q   <= acc_q;
        acc_q         <= '0;
        frame_done_q  <= 1'b1;
      end else begin
        if (hs_edge && line_act_q && ycnt_q != CntMax) ycnt_q <= ycnt_q + 10'd1;
        if (hs_edge && lcnt_q != CntMax) lcnt_q <= lcnt_q + 10'd1;
        if (s1_blank) acc_q <= acc_q + 32'(s1_red) + 32'(s1_green) + 32'(s1_blue);
      end
      rx_valid_q <= s1_blank & (state_q != StSearch);
      rx_x_q     <= xcnt_q;
      rx_y_q     <= ycnt_q;
      rx_rgb_q   <= {s1_red, s1_green, s1_blue};
    end
  end

  always_ff @(posedge vgaclk or posedge btn_reset_right) begin
    if (btn_reset_right) begin
      state_q  <= StSearch;
      good_q   <= '0;
      fbad_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StSearch: begin
          // The frame closed here started before we were listening; never graded.
          if (vs_edge) begin
            state_q <= StMeasure;
            good_q  <= '0;
            fbad_q  <= 1'b0;
          end
        end
        StMeasure: begin
          if (vs_edge) begin
            fbad_q <= 1'b0;
            if (!fbad_q && !bad_line && lcnt_q == VLines) begin
              good_q <= good_q + 2'd1;
              if (good_q + 2'd1 == LockCnt) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end else if (bad_line) begin
            fbad_q <= 1'b1;
          end
        end
        StLocked: begin
          if (bad_line || (vs_edge && lcnt_q != VLines)) begin
            state_q  <= StMeasure;
            good_q   <= '0;
            fbad_q   <= bad_line & ~vs_edge;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
          end
        end
        default: begin
          state_q  <= StSearch;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign vid.rx_valid    = rx_valid_q;
  assign vid.rx_x        = rx_x_q;
  assign vid.rx_y        = rx_y_q;
  assign vid.rx_rgb      = rx_rgb_q;
  assign vid.line_period = line_period_q;
  assign vid.frame_lines = frame_lines_q;
  assign vid.frame_sum   = frame_sum_q;
  assign vid.frame_done  = frame_done_q;
  assign vid.locked      = locked_q;
  assign vid.err         = err_q;

endmodule
